// File: rtl/uart_segment_sequencer.sv
// rtl/uart_segment_sequencer.sv - change-triggered UART segment strobe sequencer
// Synchronises demod status, captures it on change and issues one-hot segment strobes on slow ticks.
module uart_segment_sequencer #(
   parameter int NUM_CH  = 2,
   parameter int NUM_SEG = 2,
   parameter int CLK_DIV = 5000,
   localparam int SEG_W  = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               busy,
   input  logic [NUM_CH-1:0]  demod,
   output logic [NUM_SEG-1:0] transmit,
   output logic [NUM_CH-1:0]  snapshot,
   output logic [SEG_W-1:0]   seg_idx,
   output logic               active,
   output logic               pending
);

   localparam int CNT_W = $clog2(CLK_DIV);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt;
   logic               tick;
   logic [NUM_CH-1:0]  sync_q;
   logic [NUM_CH-1:0]  demod_s;
   logic [NUM_CH-1:0]  snap_d;
   logic [SEG_W-1:0]   idx_d;
   logic [NUM_SEG-1:0] tx_q;
   logic [NUM_SEG-1:0] tx_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         demod_s <= '0;
      end else begin
         sync_q  <= demod;
         demod_s <= sync_q;
      end
   end

   assign tick = (cnt == CNT_W'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      snap_d  = snapshot;
      idx_d   = seg_idx;
      tx_d    = '0;
      if (tick) begin
         case (state_q)
            IDLE: begin
               if (demod_s != snapshot) begin
                  snap_d  = demod_s;
                  idx_d   = '0;
                  state_d = ISSUE;
               end
            end
            ISSUE: begin
               if (!busy) begin
                  tx_d    = NUM_SEG'(1) << seg_idx;
                  state_d = WAIT;
               end
            end
            WAIT: begin
               if (seg_idx == SEG_W'(NUM_SEG - 1)) begin
                  state_d = IDLE;
               end else begin
                  idx_d   = seg_idx + 1'b1;
                  state_d = ISSUE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         snapshot <= '0;
         seg_idx  <= '0;
         tx_q     <= '0;
      end else begin
         state_q  <= state_d;
         snapshot <= snap_d;
         seg_idx  <= idx_d;
         tx_q     <= tx_d;
      end
   end

   // Masking with rst keeps a strobe from overlapping a reset cycle.
   assign transmit = rst ? '0 : tx_q;
   assign active   = (state_q != IDLE);
   assign pending  = active && (demod_s != snapshot);

endmodule

// File: tb/tb_uart_segment_sequencer.sv
// tb/tb_uart_segment_sequencer.sv - self-checking bench for uart_segment_sequencer
// Three instances (2-seg/div4, 5-seg/div2, 1-seg/div2) checked against a tick-position model.
module tb_uart_segment_sequencer;

   logic clk = 1'b0;
   initial forever #5 clk = ~clk;

   logic       rst0 = 1'b1;
   logic       busy0 = 1'b0;
   logic [1:0] demod0 = '0;
   logic [1:0] tx0;
   logic [1:0] snap0;
   logic [0:0] idx0;
   logic       act0, pend0;

   logic       rst12 = 1'b1;
   logic       busy12 = 1'b0;
   logic [3:0] demod1 = '0;
   logic [3:0] demod2 = '0;
   logic [4:0] tx1;
   logic [3:0] snap1;
   logic [2:0] idx1;
   logic       act1, pend1;
   logic [0:0] tx2;
   logic [3:0] snap2;
   logic [0:0] idx2;
   logic       act2, pend2;

   uart_segment_sequencer #(.NUM_CH(2), .NUM_SEG(2), .CLK_DIV(4)) dut0 (
      .clk(clk), .rst(rst0), .busy(busy0), .demod(demod0), .transmit(tx0),
      .snapshot(snap0), .seg_idx(idx0), .active(act0), .pending(pend0));

   uart_segment_sequencer #(.NUM_CH(4), .NUM_SEG(5), .CLK_DIV(2)) dut1 (
      .clk(clk), .rst(rst12), .busy(busy12), .demod(demod1), .transmit(tx1),
      .snapshot(snap1), .seg_idx(idx1), .active(act1), .pending(pend1));

   uart_segment_sequencer #(.NUM_CH(4), .NUM_SEG(1), .CLK_DIV(2)) dut2 (
      .clk(clk), .rst(rst12), .busy(busy12), .demod(demod2), .transmit(tx2),
      .snapshot(snap2), .seg_idx(idx2), .active(act2), .pending(pend2));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int cd_of(input int i);
      return (i == 0) ? 4 : 2;
   endfunction

   function automatic int ns_of(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 5 : 1);
   endfunction

   int i_rst[3], i_busy[3], i_dem[3];
   int o_tx[3], o_snap[3], o_idx[3], o_act[3], o_pend[3];

   always_comb begin
      i_rst[0] = int'(rst0);   i_rst[1] = int'(rst12);   i_rst[2] = int'(rst12);
      i_busy[0] = int'(busy0); i_busy[1] = int'(busy12); i_busy[2] = int'(busy12);
      i_dem[0] = int'(demod0); i_dem[1] = int'(demod1);  i_dem[2] = int'(demod2);
      o_tx[0] = int'(tx0);     o_tx[1] = int'(tx1);      o_tx[2] = int'(tx2);
      o_snap[0] = int'(snap0); o_snap[1] = int'(snap1);  o_snap[2] = int'(snap2);
      o_idx[0] = int'(idx0);   o_idx[1] = int'(idx1);    o_idx[2] = int'(idx2);
      o_act[0] = int'(act0);   o_act[1] = int'(act1);    o_act[2] = int'(act2);
      o_pend[0] = int'(pend0); o_pend[1] = int'(pend1);  o_pend[2] = int'(pend2);
   end

   // Sequence position j counts ticks since capture: odd = strobe slot (held by busy), even = gap.
   int m_cyc[3], m_s1[3], m_ds[3], m_snap[3], m_seq[3], m_j[3], m_idx[3], m_tx[3];

   initial begin
      for (int i = 0; i < 3; i++) begin
         m_cyc[i] = 0; m_s1[i] = 0; m_ds[i] = 0; m_snap[i] = 0;
         m_seq[i] = 0; m_j[i] = 0; m_idx[i] = 0; m_tx[i] = 0;
      end
      forever begin
         @(posedge clk);
         for (int i = 0; i < 3; i++) begin
            if (i_rst[i] != 0) begin
               m_cyc[i] = 0; m_s1[i] = 0; m_ds[i] = 0; m_snap[i] = 0;
               m_seq[i] = 0; m_j[i] = 0; m_idx[i] = 0; m_tx[i] = 0;
            end else begin
               m_tx[i] = 0;
               if (m_cyc[i] % cd_of(i) == cd_of(i) - 1) begin
                  if (m_seq[i] == 0) begin
                     if (m_ds[i] != m_snap[i]) begin
                        m_snap[i] = m_ds[i]; m_seq[i] = 1; m_j[i] = 1; m_idx[i] = 0;
                     end
                  end else if (m_j[i] % 2 == 1) begin
                     if (i_busy[i] == 0) begin
                        m_tx[i] = 1 << m_idx[i];
                        m_j[i]++;
                     end
                  end else if (m_j[i] == 2 * ns_of(i)) begin
                     m_seq[i] = 0;
                  end else begin
                     m_idx[i]++;
                     m_j[i]++;
                  end
               end
               m_cyc[i]++;
               m_ds[i] = m_s1[i];
               m_s1[i] = i_dem[i];
            end
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("model dut%0d transmit", i), o_tx[i], m_tx[i]);
         chk($sformatf("model dut%0d snapshot", i), o_snap[i], m_snap[i]);
         chk($sformatf("model dut%0d seg_idx", i), o_idx[i], m_idx[i]);
         chk($sformatf("model dut%0d active", i), o_act[i], m_seq[i]);
         chk($sformatf("model dut%0d pending", i), o_pend[i],
             (m_seq[i] != 0 && m_ds[i] != m_snap[i]) ? 1 : 0);
         chk($sformatf("dut%0d transmit one-hot", i), ($countones(o_tx[i]) <= 1) ? 1 : 0, 1);
      end
   end

   int p0 = 0;
   int q12 = 0;

   task goto0(input int p);
      while (p0 < p) begin
         @(posedge clk);
         #1;
         p0++;
      end
   endtask

   task goto12(input int q);
      while (q12 < q) begin
         @(posedge clk);
         #1;
         q12++;
      end
   endtask

   initial begin
      fork
         begin
            repeat (3) @(posedge clk);
            #1;
            chk("reset transmit", int'(tx0), 0);
            chk("reset snapshot", int'(snap0), 0);
            chk("reset seg_idx", int'(idx0), 0);
            chk("reset active", int'(act0), 0);
            chk("reset pending", int'(pend0), 0);
            @(negedge clk);
            demod0 = 2'b01;
            rst0 = 1'b0;
            p0 = 0;
            goto0(3);  chk("basic idle before tick", int'(act0), 0);
            goto0(4);  chk("basic capture", int'(snap0), 1);
                       chk("basic active", int'(act0), 1);
            goto0(8);  chk("basic strobe0", int'(tx0), 1);
            goto0(9);  chk("basic strobe0 width", int'(tx0), 0);
            goto0(16); chk("basic strobe1", int'(tx0), 2);
            goto0(19); chk("basic still active", int'(act0), 1);
            goto0(20); chk("basic active falls", int'(act0), 0);
                       chk("basic last seg_idx", int'(idx0), 1);
            @(negedge clk); demod0 = 2'b10;
            goto0(24); chk("stall capture", int'(snap0), 2);
            @(negedge clk); busy0 = 1'b1;
            for (int p = 25; p <= 39; p++) begin
               goto0(p);
               chk("stall no strobe", int'(tx0), 0);
               chk("stall seg_idx", int'(idx0), 0);
               if (p == 36) begin
                  @(negedge clk);
                  busy0 = 1'b0;
               end
            end
            goto0(40); chk("stall release strobe", int'(tx0), 1);
            goto0(48); chk("stall strobe1", int'(tx0), 2);
            goto0(52); chk("stall seq end", int'(act0), 0);
            @(negedge clk); demod0 = 2'b01;
            goto0(56); chk("change capture", int'(snap0), 1);
            goto0(60); chk("change strobe0", int'(tx0), 1);
            @(negedge clk); demod0 = 2'b11;
            goto0(61); chk("change pending early", int'(pend0), 0);
            goto0(62); chk("change pending", int'(pend0), 1);
                       chk("change snapshot held", int'(snap0), 1);
            goto0(72); chk("change seq end", int'(act0), 0);
            goto0(76); chk("change new capture", int'(snap0), 3);
                       chk("change new active", int'(act0), 1);
            goto0(92); chk("change second end", int'(act0), 0);
            @(negedge clk); demod0 = 2'b01;
            goto0(108); chk("rstmid strobe1", int'(tx0), 2);
            goto0(109); chk("rstmid in wait", int'(idx0), 1);
            @(negedge clk); rst0 = 1'b1;
            goto0(110);
            chk("rstmid transmit", int'(tx0), 0);
            chk("rstmid snapshot", int'(snap0), 0);
            chk("rstmid seg_idx", int'(idx0), 0);
            chk("rstmid active", int'(act0), 0);
            chk("rstmid pending", int'(pend0), 0);
            @(negedge clk); rst0 = 1'b0;
            goto0(113); chk("rstmid no early restart", int'(act0), 0);
            goto0(114); chk("rstmid restart capture", int'(snap0), 1);
                        chk("rstmid restart active", int'(act0), 1);
            goto0(130); chk("rstmid restart end", int'(act0), 0);
            for (int p = 131; p <= 210; p++) begin
               goto0(p);
               chk("quiet transmit", int'(tx0), 0);
               chk("quiet active", int'(act0), 0);
            end
         end
         begin
            int n1, n2, maxidx;
            n1 = 0; n2 = 0; maxidx = 0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            demod1 = 4'b1010;
            demod2 = 4'b0001;
            rst12 = 1'b0;
            q12 = 0;
            for (int q = 1; q <= 40; q++) begin
               goto12(q);
               if (q == 4) chk("sweep5 capture", int'(snap1), 10);
               if (tx1 != 0) begin
                  chk("sweep5 strobe order", int'(tx1), 1 << n1);
                  chk("sweep5 strobe time", q, 6 + 4 * n1);
                  n1++;
               end
               if (int'(idx1) > maxidx) maxidx = int'(idx1);
               if (tx2 != 0) begin
                  chk("sweep1 strobe", int'(tx2), 1);
                  chk("sweep1 strobe time", q, 6);
                  n2++;
               end
            end
            chk("sweep5 strobe count", n1, 5);
            chk("sweep5 max seg_idx", maxidx, 4);
            chk("sweep5 done", int'(act1), 0);
            chk("sweep1 strobe count", n2, 1);
            chk("sweep1 seg_idx", int'(idx2), 0);
            chk("sweep1 done", int'(act2), 0);
         end
      join
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_segment_sequencer.md
# uart_segment_sequencer

Parametrised change-triggered transmit sequencer that sits between the demodulator outputs and the UART transmitter. It synchronises `NUM_CH` demod status bits and watches them for change on an internal slow tick. On a change it captures a snapshot and issues `NUM_SEG` one-hot transmit strobes in order. Each strobe is gated by the UART `busy` handshake, and the divider is built in so no separate enable block is needed.

## Interface
- `NUM_CH`, default 2: number of demod status inputs; ≥1.
- `NUM_SEG`, default 2: number of transmit segments per sequence; ≥1.
- `CLK_DIV`, default 5000: clk cycles per tick (100 MHz → 20 kHz); ≥2.
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous active-high reset.
- `busy`, input, 1: UART transmitter busy; a strobe is never issued while high.
- `demod`, input, `NUM_CH`: demod status bits; asynchronous to clk.
- `transmit`, output, `NUM_SEG`: one-hot, one-clk request pulse; bit k starts segment k.
- `snapshot`, output, `NUM_CH`: demod value captured at sequence start; it is the payload source for the UART.
- `seg_idx`, output, max(1,$clog2(`NUM_SEG`)): index of the current or last segment.
- `active`, output, 1: high while a sequence is in progress (state ≠ IDLE).
- `pending`, output, 1: high when `active` and the synchronised demod value ≠ `snapshot`.

## Operation
- **Synchroniser:** `demod` passes through a 2-flop synchroniser to give `demod_s`. Its reset value is 0.
- **Tick divider:** `cnt` counts 0..`CLK_DIV`-1 and wraps. `tick` = (`cnt`==`CLK_DIV`-1) and lasts one cycle. On reset `cnt`=0.
- **States:** IDLE, ISSUE, WAIT. Transitions are evaluated only on cycles where `tick`=1, except reset.
- **IDLE, on tick:**
  - If `demod_s` ≠ `snapshot`: `snapshot`←`demod_s`, `seg_idx`←0, go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE, on tick:**
  - If `busy`=0: `transmit`[`seg_idx`]←1 for the following cycle only, go to WAIT.
  - If `busy`=1: stay in ISSUE with no strobe. The stall is unbounded.
- **WAIT, on tick:**
  - If `seg_idx`==`NUM_SEG`-1: go to IDLE.
  - Otherwise `seg_idx`←`seg_idx`+1, go to ISSUE.
- **Changes during a sequence:** `snapshot` is held until the sequence ends, and `pending` flags the change. On the first IDLE tick after the sequence, the mismatch starts a new sequence carrying the newest value. Intermediate values are not queued.
- **`NUM_SEG`=1:** ISSUE → WAIT → IDLE; `seg_idx` stays at 0.
- **Reset values:**
  - `transmit`=0, `snapshot`=0, `seg_idx`=0, `active`=0, `pending`=0.
  - State = IDLE, `cnt`=0, synchroniser = 0.
- **Reset mid-sequence:** the sequence is abandoned at once, no further strobes are issued, and all outputs return to their reset values on the next cycle.
- **Power-up with nonzero demod:** `demod_s` ≠ 0 (the `snapshot` reset value), so a sequence is issued on the first tick.
- `transmit` is never multi-hot, and is never asserted in the same cycle as `rst`.

## Timing
- Change to capture: from a `demod` change to the `snapshot` update takes 2 cycles (synchroniser) plus the wait to the next tick, plus 1 cycle.
- First tick after reset release: `tick` is high in the `CLK_DIV`-th cycle after reset release.
- Strobe timing:
  - `transmit` is registered and is high in the cycle after the ISSUE tick.
  - Strobes for consecutive segments are 2·`CLK_DIV` cycles apart when `busy` stays low.
- Sequence length: with no stall, a sequence takes 2·`NUM_SEG`+1 ticks, from the capture tick to the return to IDLE.
- Output timing: `active` and `pending` are registered or derived from registered state only, with no combinational path from `busy` or `demod`.
- `busy` handshake: `busy` is sampled only on tick cycles. The UART must assert `busy` within `CLK_DIV` cycles of a strobe if it needs to hold off the next one.

## Test plan
- **Basic two-segment sequence** (`CLK_DIV`=4, `NUM_CH`=2, `NUM_SEG`=2): reset, then `demod`=2'b01 → `snapshot`=01 on the first tick. Pulses follow: `transmit`=01 one tick later, then 10 two ticks after that, each 1 cycle wide. `active` then falls.
- **Busy stall:** hold `busy`=1 for 3 ticks while in ISSUE → no strobe during the stall. The strobe follows 1 cycle after the first tick with `busy`=0, and `seg_idx` is unchanged meanwhile.
- **Change mid-sequence:** move `demod` 01→11 during segment 0 → `pending`=1 while `snapshot` stays 01. After the return to IDLE, a second sequence starts with `snapshot`=11.
- **Reset mid-sequence:** assert `rst` for 1 cycle while in WAIT → `transmit`, `snapshot`, `seg_idx`, `active` and `pending` are all 0 next cycle. With `demod` still 01, a new sequence starts `CLK_DIV` cycles later.
- **Parameter sweep** (`NUM_SEG`=1 and `NUM_SEG`=5, `NUM_CH`=4, `CLK_DIV`=2): for `NUM_SEG`=5, strobes go bits 0..4 in order, one-hot, with `seg_idx` reaching 4. For `NUM_SEG`=1, a single strobe on bit 0.
- **No change:** hold `demod` constant for 20 ticks after the initial sequence → no `transmit` activity and `active`=0 throughout.
